layer_ctrl: RTL and testbench
=============================

// Module: layer_ctrl
// PURPOSE
// Sequencer for one `layer` instance. Accepts an input vector plus a weight-set index,
// loads that set's weights serially from a shared weight memory into the layer's w_i,
// waits for the layer to settle, then captures the layer output and returns it over a
// valid/ready handshake. Caches the loaded set: a repeat request for the same set skips the load.
// PARAMETERS
// LENGHT_I  2    layer input count
// LENGHT_O  1    layer output count
// WIDTH_W   9    weight width, two's complement, passed through unchanged
// WIDTH_I   1    width of each input element
// WIDTH_O   10   width of each layer output element
// NUM_SETS  4    number of weight sets stored in the weight memory
// LAT       2    cycles from stable w_i/l_in to valid l_out; must be >=1
// (local) N = LENGHT_I*LENGHT_O; SW = max(1,$clog2(NUM_SETS)); AW = max(1,$clog2(NUM_SETS*N))
// PORTS
// clk       in   1                 clock, rising edge
// rst       in   1                 synchronous reset, active-high
// in_valid  in   1                 request valid
// in_ready  out  1                 request accepted when in_valid & in_ready
// in_data   in   LENGHT_I*WIDTH_I  input vector for the layer
// in_set    in   SW                weight-set index for this request
// inv       in   1                 1-cycle pulse: weight memory rewritten, drop cached set
// wm_addr   out  AW                weight memory read address
// wm_rdata  in   WIDTH_W           weight memory read data, 1-cycle read latency
// w_i       out  N*WIDTH_W         weights to the layer, element k = [k*WIDTH_W +: WIDTH_W]
// l_in      out  LENGHT_I*WIDTH_I  input vector to the layer
// l_out     in   LENGHT_O*WIDTH_O  layer output
// res_valid out  1                 result valid
// res_ready in   1                 result consumed when res_valid & res_ready
// res_data  out  LENGHT_O*WIDTH_O  captured layer output
// busy      out  1                 high in every state except IDLE
// BEHAVIOUR
// - Reset (sync, rst=1): state IDLE. Cleared to 0: w_i, l_in, wm_addr, res_data, res_valid,
//   cache flag, cached set. in_ready forced 0 while rst=1. Reset mid-operation aborts with no result.
// - in_ready = (state==IDLE) & ~rst. busy = (state!=IDLE).
// - States: IDLE, LOAD, SETTLE, HOLD.
// - IDLE: on accept at edge t, register l_in<=in_data and req_set<=in_set.
//   Cache hit (cache flag=1, cached set==in_set, no inv in cycle t) -> SETTLE. Otherwise -> LOAD.
// - LOAD: counter c runs 0..N, N+1 cycles total.
//   For c<N: wm_addr = req_set*N + c.
//   For c>=1: w_i[c-1] <= wm_rdata.
//   After c==N: set cache flag, cached set <= req_set, go to SETTLE. wm_addr holds its last value.
// - SETTLE: LAT cycles, w_i and l_in stable. On the last cycle res_data <= l_out, res_valid <= 1,
//   go to HOLD.
// - HOLD: res_valid=1; res_data and w_i stable. On res_ready go to IDLE next cycle, res_valid <= 0.
//   No same-cycle re-accept: in_ready is not asserted in HOLD.
// - Latency, accept edge t: hit -> res_valid at t+LAT+1; miss -> res_valid at t+N+LAT+2.
// - inv: clears the cache flag at the next edge in any state. If inv arrives during LOAD,
//   the load finishes and the result is delivered, but the cache flag ends at 0.
// - in_set >= NUM_SETS: address wraps modulo 2^AW; no check. Behaviour is undefined, do not rely on it.
// - l_in holds the last accepted vector between requests; w_i holds the last loaded set.
// TESTING (bench models layer as: l_out = sum(w_i[k]*l_in[k]) delayed LAT; memory set0={5,-3}, set1={-2,4})
// 1 rst high 3 cycles mid-LOAD -> res_valid=0, w_i=0, busy=0, in_ready=0 during reset, 1 the cycle after.
// 2 miss: set0, in_data={0,1}=in[1],in[0] at edge t -> wm_addr 0,1; w_i={5,-3}; res_valid at t+6; res_data=5.
// 3 hit: set0 again, in={1,1} -> no wm_addr activity; res_valid at t+3; res_data=2.
// 4 switch: set1, in={1,1} -> wm_addr 2,3; w_i={-2,4}; res_data=2; then res_ready held 0 for 5 cycles
//   -> res_valid and res_data stable, in_ready=0 throughout.
// 5 inv during HOLD, then set1 request -> reload occurs (wm_addr 2,3) despite same set.
// 6 back-to-back: in_valid held high, res_ready=1 -> each request spaced by one IDLE cycle,
//   results in order, none dropped.

Source files
------------

// File: rtl/layer_ctrl.sv
// layer_ctrl: sequencer for a single `layer` instance.
//
// On an accepted request it latches the input vector and weight-set index. It then
// streams that set's N weights out of a shared, 1-cycle-latency weight memory into
// w_i, unless that set is already loaded. After waiting LAT cycles for the layer to
// settle, it captures l_out and presents it on a valid/ready result port.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     request handshake; in_data = layer input vector, in_set = weight set
//   inv                   single-cycle pulse: weight memory contents changed, forget cached set
//   wm_addr/wm_rdata      weight memory read port (data returns one cycle after address)
//   w_i, l_in             drive the layer (weights, input vector)
//   l_out                 layer output, valid LAT cycles after w_i/l_in are stable
//   res_valid/res_ready   result handshake; res_data = captured layer output
//   busy                  high whenever the sequencer is not idle
module layer_ctrl #(
    parameter int LENGHT_I = 2,
    parameter int LENGHT_O = 1,
    parameter int WIDTH_W  = 9,
    parameter int WIDTH_I  = 1,
    parameter int WIDTH_O  = 10,
    parameter int NUM_SETS = 4,
    parameter int LAT      = 2,
    localparam int N  = LENGHT_I * LENGHT_O,
    localparam int SW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int AW = (NUM_SETS * N > 1) ? $clog2(NUM_SETS * N) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LENGHT_I*WIDTH_I-1:0]  in_data,
    input  logic [SW-1:0]                in_set,
    input  logic                         inv,
    output logic [AW-1:0]                wm_addr,
    input  logic [WIDTH_W-1:0]           wm_rdata,
    output logic [N*WIDTH_W-1:0]         w_i,
    output logic [LENGHT_I*WIDTH_I-1:0]  l_in,
    input  logic [LENGHT_O*WIDTH_O-1:0]  l_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [LENGHT_O*WIDTH_O-1:0]  res_data,
    output logic                         busy
);

    // Load counter spans 0..N; settle counter spans 0..LAT-1.
    localparam int CW = (N + 1 > 1) ? $clog2(N + 1) : 1;
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, HOLD} state_t;

    state_t                         state_reg, state_next;
    logic [CW-1:0]                  load_cnt_reg;
    logic [LW-1:0]                  settle_cnt_reg;
    logic [SW-1:0]                  req_set_reg;
    logic                           cache_vld_reg;
    logic [SW-1:0]                  cache_set_reg;
    logic                           inv_seen_reg;
    logic [AW-1:0]                  wm_addr_reg;
    logic [LENGHT_I*WIDTH_I-1:0]    l_in_reg;
    logic [LENGHT_O*WIDTH_O-1:0]    res_data_reg;
    logic                           res_valid_reg;

    logic accept, hit, load_last, settle_last;

    // Base address of a set plus element offset; wraps modulo 2^AW.
    function automatic logic [AW-1:0] set_addr(input logic [SW-1:0] set, input logic [CW-1:0] cnt);
        return AW'(set) * AW'(N) + AW'(cnt);
    endfunction

    assign accept      = in_valid && in_ready;
    // An inv in the accept cycle invalidates the cache before the hit decision.
    assign hit         = cache_vld_reg && (cache_set_reg == in_set) && !inv;
    assign load_last   = (state_reg == LOAD) && (load_cnt_reg == CW'(N));
    assign settle_last = (state_reg == SETTLE) && (settle_cnt_reg == LW'(LAT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)      state_next = hit ? SETTLE : LOAD;
            LOAD:    if (load_last)   state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = HOLD;
            HOLD:    if (res_ready)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_reg == IDLE) && !rst;
        busy     = (state_reg != IDLE);
    end

    // ---------------- Datapath / control registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            req_set_reg    <= '0;
            cache_vld_reg  <= 1'b0;
            cache_set_reg  <= '0;
            inv_seen_reg   <= 1'b0;
            wm_addr_reg    <= '0;
            l_in_reg       <= '0;
            res_data_reg   <= '0;
            res_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        l_in_reg     <= in_data;
                        req_set_reg  <= in_set;
                        inv_seen_reg <= 1'b0;
                        if (hit) begin
                            settle_cnt_reg <= '0;
                        end else begin
                            // First address goes out now so its data lands in LOAD cycle 1.
                            wm_addr_reg   <= set_addr(in_set, '0);
                            load_cnt_reg  <= '0;
                            cache_vld_reg <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    load_cnt_reg <= load_cnt_reg + CW'(1);
                    if (load_cnt_reg < CW'(N - 1))
                        wm_addr_reg <= set_addr(req_set_reg, load_cnt_reg + CW'(1));
                    // An inv seen mid-load means the weights just loaded may be stale.
                    if (inv)
                        inv_seen_reg <= 1'b1;
                    if (load_last) begin
                        cache_vld_reg  <= !(inv || inv_seen_reg);
                        cache_set_reg  <= req_set_reg;
                        settle_cnt_reg <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + LW'(1);
                    if (settle_last) begin
                        res_data_reg  <= l_out;
                        res_valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready)
                        res_valid_reg <= 1'b0;
                end
                default: ;
            endcase
            if (inv)
                cache_vld_reg <= 1'b0;
        end
    end

    // ---------------- Weight registers ----------------
    // Element gi captures memory data in LOAD cycle gi+1 (one cycle after its address).
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_w
            logic [WIDTH_W-1:0] w_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    w_reg <= '0;
                else if ((state_reg == LOAD) && (load_cnt_reg == CW'(gi + 1)))
                    w_reg <= wm_rdata;
            end
            assign w_i[gi*WIDTH_W +: WIDTH_W] = w_reg;
        end
    endgenerate

    assign wm_addr   = wm_addr_reg;
    assign l_in      = l_in_reg;
    assign res_data  = res_data_reg;
    assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_layer_ctrl.sv
// Testbench for layer_ctrl: weight memory and layer are modelled here; expected
// results are queued on request accept and compared on result handshake.
module tb_layer_ctrl;

    localparam int LAT = 2;
    localparam int N   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_data;
    logic [1:0]  in_set;
    logic        inv;
    logic [2:0]  wm_addr;
    logic [8:0]  wm_rdata;
    logic [17:0] w_i;
    logic [1:0]  l_in;
    logic [9:0]  l_out;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_data;
    logic        busy;

    always #5 clk = ~clk;

    layer_ctrl #(
        .LENGHT_I(2), .LENGHT_O(1), .WIDTH_W(9), .WIDTH_I(1),
        .WIDTH_O(10), .NUM_SETS(4), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_set(in_set),
        .inv(inv),
        .wm_addr(wm_addr), .wm_rdata(wm_rdata),
        .w_i(w_i), .l_in(l_in), .l_out(l_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // Weight memory, registered read.
    logic [8:0] mem [0:7];
    always @(posedge clk) wm_rdata <= mem[wm_addr];

    // Layer model: weighted sum, LAT-1 register stages so it is valid when
    // sampled LAT edges after w_i/l_in settle.
    logic [9:0] l_sum;
    always_comb begin
        l_sum = '0;
        for (int k = 0; k < 2; k++)
            if (l_in[k]) l_sum = l_sum + {w_i[k*9+8], w_i[k*9 +: 9]};
    end
    always @(posedge clk) l_out <= l_sum;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int t_acc = 0;
    int last_res_cyc = 0;
    bit b2b_mode = 1'b0;
    bit have_prev = 1'b0;

    function automatic logic [9:0] model(logic [1:0] set, logic [1:0] d);
        logic [9:0] s;
        logic [8:0] w;
        s = '0;
        for (int k = 0; k < 2; k++) begin
            w = mem[int'(set) * 2 + k];
            if (d[k]) s = s + {w[8], w};
        end
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard handshakes seen before the edge, then advance.
    task automatic step();
        bit acc, res;
        acc = in_valid && in_ready;
        res = res_valid && res_ready;
        if (acc) sb_q.push_back(model(in_set, in_data));
        if (res) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) chk("sb_result", 32'(res_data), 32'(sb_q.pop_front()));
            n_pop++;
        end
        @(posedge clk); #1;
        if (res) last_res_cyc = cyc;
        if (acc) begin
            if (b2b_mode && have_prev) chk("b2b_gap", cyc - last_res_cyc, 1);
            have_prev = 1'b1;
            t_acc = cyc;
        end
        $display("cyc=%0d acc=%0b res=%0b wm_addr=%0d res_valid=%0b res_data=%0h",
                 cyc, acc, res, wm_addr, res_valid, res_data);
    endtask

    task automatic issue(logic [1:0] set, logic [1:0] d);
        in_valid = 1'b1; in_set = set; in_data = d;
        for (int i = 0; i < 30 && !in_ready; i++) step();
        chk("accept_ready", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 30 && !res_valid; i++) step();
        chk("res_timeout", 32'(res_valid), 32'(1));
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 32'(0));
    endtask

    // Miss: addresses set*N, set*N+1; result registered N+LAT+1 edges after accept
    // (seen high at edge t+N+LAT+2).
    task automatic run_miss(logic [1:0] set, logic [1:0] d);
        issue(set, d);
        chk("addr0", 32'(wm_addr), int'(set) * 2);
        step();
        chk("addr1", 32'(wm_addr), int'(set) * 2 + 1);
        wait_res();
        chk("lat_miss", cyc - t_acc, N + LAT + 1);
    endtask

    // Hit: no memory traffic; result registered LAT edges after accept.
    task automatic run_hit(logic [1:0] set, logic [1:0] d);
        logic [2:0] a0;
        a0 = wm_addr;
        issue(set, d);
        wait_res();
        chk("lat_hit", cyc - t_acc, LAT);
        chk("addr_hold", 32'(wm_addr), 32'(a0));
    endtask

    logic [1:0] tbl_set [0:3];
    logic [1:0] tbl_dat [0:3];

    initial begin
        int idx, p0;
        bit acc_now;
        mem[0] = 9'd5;     mem[1] = 9'h1FD;  // set0 = {5,-3}
        mem[2] = 9'h1FE;   mem[3] = 9'd4;    // set1 = {-2,4}
        mem[4] = 9'd1;     mem[5] = 9'd1;
        mem[6] = 9'd1;     mem[7] = 9'd1;
        tbl_set[0] = 2'd0; tbl_dat[0] = 2'b11;
        tbl_set[1] = 2'd0; tbl_dat[1] = 2'b01;
        tbl_set[2] = 2'd1; tbl_dat[2] = 2'b10;
        tbl_set[3] = 2'd1; tbl_dat[3] = 2'b10;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_set = '0; inv = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", 32'(in_ready), 32'(0));
        end
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'(1));

        // 1: reset in the middle of a load aborts with no result
        issue(2'd1, 2'b11);
        step();
        step();
        chk("midload_busy", 32'(busy), 32'(1));
        chk("midload_w0", 32'(w_i[8:0]), 32'h1FE);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst2_in_ready", 32'(in_ready), 32'(0));
        end
        chk("rst2_res_valid", 32'(res_valid), 32'(0));
        chk("rst2_w_i", 32'(w_i), 32'(0));
        chk("rst2_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        sb_q.delete();
        step();
        chk("rst2_ready_after", 32'(in_ready), 32'(1));
        chk("rst2_no_result", 32'(res_valid), 32'(0));

        // 2: miss on set0
        run_miss(2'd0, 2'b01);
        chk("w_set0", 32'(w_i), {14'd0, 9'h1FD, 9'h005});
        chk("res_set0_a", 32'(res_data), 32'd5);
        consume();

        // 3: hit on set0
        run_hit(2'd0, 2'b11);
        chk("res_set0_b", 32'(res_data), 32'd2);
        consume();

        // 4: switch to set1, then stall the result
        run_miss(2'd1, 2'b11);
        chk("w_set1", 32'(w_i), {14'd0, 9'h004, 9'h1FE});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(res_valid), 32'(1));
            chk("stall_ready", 32'(in_ready), 32'(0));
            chk("stall_data", 32'(res_data), 32'd2);
        end
        consume();

        // 5: inv during HOLD forces a reload of the same set
        run_hit(2'd1, 2'b10);
        inv = 1'b1;
        step();
        inv = 1'b0;
        consume();
        run_miss(2'd1, 2'b01);
        chk("res_reload", 32'(res_data), 32'h3FE);
        consume();

        // inv during LOAD: load completes, result delivered, cache stays empty
        issue(2'd0, 2'b10);
        inv = 1'b1;
        step();
        inv = 1'b0;
        wait_res();
        chk("lat_inv_load", cyc - t_acc, N + LAT + 1);
        consume();
        run_miss(2'd0, 2'b10);
        consume();

        // 6: back-to-back requests with in_valid and res_ready held high
        b2b_mode = 1'b1; have_prev = 1'b0;
        p0 = n_pop; idx = 0;
        in_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 200 && (idx < 4 || sb_q.size() != 0); i++) begin
            if (idx < 4) begin
                in_set = tbl_set[idx]; in_data = tbl_dat[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) idx++;
        end
        in_valid = 1'b0; res_ready = 1'b0; b2b_mode = 1'b0;
        chk("b2b_count", n_pop - p0, 4);
        chk("b2b_queue_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
